hazard_control_unit: RTL

Pipeline hazard and redirect controller for the 5-stage RV32I core. Produces the `Do_Stall`, `Is_Branch_Taken` and `Branch_Address` controls that the next-PC selector consumes, plus the IF/ID and ID/EX hold and flush controls. It covers three cases: load-use bubbles, taken branches and jumps resolved in EX, and multi-cycle data-memory waits. A taken branch that resolves during a memory wait is captured and replayed when the wait ends.

---
 rtl/core_pkg.sv | 15 +
 rtl/hazard_perf_counters.sv | 27 ++
 rtl/hazard_control_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, the x0 index and the hazard FSM state encoding.
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] X0_IDX = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HOLD       = 2'd1,
        ST_HOLD_REDIR = 2'd2
    } hcu_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running wrap-around performance counters for stall cycles and PC redirects.
module hazard_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_en,
    input  logic             redirect_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (stall_en) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect_en) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use, branch-redirect and memory-wait hazard controller; a redirect resolved
// during a memory freeze is captured and replayed once the freeze lifts.
module hazard_control_unit #(
    parameter int unsigned XLEN  = core_pkg::XLEN,
    parameter int unsigned REG_W = core_pkg::REG_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] Id_Rs1,
    input  logic [REG_W-1:0] Id_Rs2,
    input  logic             Id_Use_Rs1,
    input  logic             Id_Use_Rs2,
    input  logic [REG_W-1:0] Ex_Rd,
    input  logic             Ex_Mem_Read,
    input  logic             Ex_Is_Branch,
    input  logic             Ex_Is_Jump,
    input  logic             Ex_Branch_Cond,
    input  logic [XLEN-1:0]  Ex_Alu_Out,
    input  logic             Mem_Busy,
    output logic             Do_Stall,
    output logic             Is_Branch_Taken,
    output logic [XLEN-1:0]  Branch_Address,
    output logic             Pipe_Hold,
    output logic             If_Id_Hold,
    output logic             If_Id_Flush,
    output logic             Id_Ex_Flush,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Redirect_Count
);

    import core_pkg::*;

    hcu_state_e      state;
    hcu_state_e      state_next;
    logic [XLEN-1:0] pend_addr;
    logic [XLEN-1:0] pend_addr_next;
    logic            taken;
    logic            load_use;

    assign taken    = Ex_Is_Jump | (Ex_Is_Branch & Ex_Branch_Cond);
    assign load_use = Ex_Mem_Read & (Ex_Rd != REG_W'(X0_IDX)) &
                      ((Id_Use_Rs1 & (Id_Rs1 == Ex_Rd)) |
                       (Id_Use_Rs2 & (Id_Rs2 == Ex_Rd)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_RUN;
            pend_addr <= '0;
        end else begin
            state     <= state_next;
            pend_addr <= pend_addr_next;
        end
    end

    // Outputs are combinational: the next-PC mux consumes them in the same cycle.
    always_comb begin
        state_next      = state;
        pend_addr_next  = pend_addr;
        Do_Stall        = 1'b0;
        Is_Branch_Taken = 1'b0;
        Branch_Address  = Ex_Alu_Out;
        Pipe_Hold       = 1'b0;
        If_Id_Hold      = 1'b0;
        If_Id_Flush     = 1'b0;
        Id_Ex_Flush     = 1'b0;

        if (Rst) begin
            Branch_Address = '0;
            state_next     = ST_RUN;
            pend_addr_next = '0;
        end else if (Mem_Busy) begin
            Pipe_Hold = 1'b1;
            Do_Stall  = 1'b1;
            // A captured target is never overwritten by later wrong-path EX contents.
            if (state != ST_HOLD_REDIR) begin
                if (taken) begin
                    pend_addr_next = Ex_Alu_Out;
                    state_next     = ST_HOLD_REDIR;
                end else begin
                    state_next = ST_HOLD;
                end
            end
        end else begin
            state_next = ST_RUN;
            if (state == ST_HOLD_REDIR) begin
                Is_Branch_Taken = 1'b1;
                Branch_Address  = pend_addr;
                If_Id_Flush     = 1'b1;
                Id_Ex_Flush     = 1'b1;
            end else if (taken) begin
                Is_Branch_Taken = 1'b1;
                If_Id_Flush     = 1'b1;
                Id_Ex_Flush     = 1'b1;
            end else if (load_use) begin
                Do_Stall    = 1'b1;
                If_Id_Hold  = 1'b1;
                Id_Ex_Flush = 1'b1;
            end
        end
    end

    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk            (Clk),
        .rst            (Rst),
        .stall_en       (Do_Stall),
        .redirect_en    (Is_Branch_Taken),
        .stall_cycles   (Stall_Cycles),
        .redirect_count (Redirect_Count)
    );

endmodule
